// File: rtl/seq_divider.sv
// Multi-cycle signed divider using restoring shift-subtract on magnitudes.
// It produces one quotient bit per clock, then applies the signs in a final fix-up cycle.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             div_zero,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] qmag_q, qmag_d;
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             div_zero_q, div_zero_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // The partial remainder stays below |divisor|, so the shifted value minus
   // |divisor| always fits a WIDTH+1-bit signed result.
   assign shifted = {prem_q, qmag_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dmag_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prem_d     = prem_q;
      qmag_d     = qmag_q;
      dmag_d     = dmag_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      dz_d       = dz_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      div_zero_d = div_zero_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               qmag_d  = dividend[WIDTH-1] ? -dividend : dividend;
               dmag_d  = divisor[WIDTH-1] ? -divisor : divisor;
               prem_d  = '0;
               cnt_d   = '0;
               dz_d    = (divisor == '0);
               state_d = (divisor == '0) ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            if (!trial[WIDTH]) begin
               prem_d = trial[WIDTH-1:0];
               qmag_d = {qmag_q[WIDTH-2:0], 1'b1};
            end else begin
               prem_d = shifted[WIDTH-1:0];
               qmag_d = {qmag_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (dz_q) begin
               quot_d     = '0;
               rem_d      = dvd_q;
               div_zero_d = 1'b1;
               ovf_d      = 1'b0;
            end else if (dvd_q == MOST_NEG && dvs_q == '1) begin
               quot_d     = MOST_NEG;
               rem_d      = '0;
               div_zero_d = 1'b0;
               ovf_d      = 1'b1;
            end else begin
               quot_d     = (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]) ? -qmag_q : qmag_q;
               rem_d      = dvd_q[WIDTH-1] ? -prem_q : prem_q;
               div_zero_d = 1'b0;
               ovf_d      = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         prem_q     <= '0;
         qmag_q     <= '0;
         dmag_q     <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         dz_q       <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prem_q     <= prem_d;
         qmag_q     <= qmag_d;
         dmag_q     <= dmag_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         dz_q       <= dz_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         div_zero_q <= div_zero_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign quot     = quot_q;
   assign rem      = rem_q;
   assign div_zero = div_zero_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8) with hand-computed expected results.
// It checks latency, the done pulse, signs, flags, start handling and asynchronous reset.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quot;
   logic [7:0] rem;
   logic       div_zero;
   logic       ovf;

   int n_checks = 0;
   int n_fail   = 0;

   seq_divider #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quot     (quot),
      .rem      (rem),
      .div_zero (div_zero),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_checks++;
      if (obs !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
      end
   endtask

   // Counts edges from the current point until done is seen (bounded).
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!done && n < 40);
   endtask

   task automatic check_result(input string tag, input int lat, input int want_lat,
                               input logic [7:0] q, input logic [7:0] r,
                               input logic dz, input logic ov);
      chk({tag, " latency"}, lat, want_lat);
      chk({tag, " quot"}, quot, q);
      chk({tag, " rem"}, rem, r);
      chk({tag, " div_zero"}, div_zero, dz);
      chk({tag, " ovf"}, ovf, ov);
      chk({tag, " busy_low"}, busy, 1'b0);
      $display("op %s: quot=0x%02h rem=0x%02h dz=%0b ovf=%0b lat=%0d", tag, quot, rem,
               div_zero, ovf, lat);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] q, input logic [7:0] r,
                         input logic dz, input logic ov, input int want_lat);
      int lat;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk({tag, " busy"}, busy, 1'b1);
      wait_done(lat);
      check_result(tag, lat, want_lat, q, r, dz, ov);
      @(posedge clk);
      #1;
      chk({tag, " done_pulse"}, done, 1'b0);
   endtask

   initial begin
      int lat;
      int dones;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      @(posedge clk);
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset quot", quot, 8'h00);
      chk("reset rem", rem, 8'h00);
      chk("reset flags", {div_zero, ovf}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      run_op("100/7",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 9);
      run_op("-100/7",  8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 9);
      run_op("100/-7",  8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 9);
      run_op("-100/-7", 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 9);
      run_op("-128/-1", 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 9);
      run_op("-128/1",  8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 9);
      run_op("55/0",    8'd55,  8'h00,  8'h00, 8'h37, 1'b1, 1'b0, 1);
      run_op("6/3",     8'd6,   8'd3,   8'h02, 8'h00, 1'b0, 1'b0, 9);

      // A start pulse mid-operation must be ignored; a start during done is accepted.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 8'd20;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(lat);
      check_result("ignore", lat + 3, 9, 8'h0E, 8'h02, 1'b0, 1'b0);
      start    = 1'b1;
      dividend = 8'd6;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b busy", busy, 1'b1);
      chk("b2b done_pulse", done, 1'b0);
      wait_done(lat);
      check_result("b2b", lat, 9, 8'h02, 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in the middle of the calculation.
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst busy", busy, 1'b0);
      chk("arst done", done, 1'b0);
      chk("arst quot", quot, 8'h00);
      chk("arst rem", rem, 8'h00);
      chk("arst flags", {div_zero, ovf}, 2'b00);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("arst no_done", dones, 0);
      run_op("127/-128", 8'd127, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
